adder_share_arbiter: RTL and testbench
======================================

// Module: adder_share_arbiter
// PURPOSE
//  Round-robin arbiter/sequencer that time-shares one external ripple_adder
//  (x, y, z -> s, c) among N_REQ requesters. It latches the winner's operands,
//  drives the adder, and waits SETTLE_CYC cycles for the ripple carry to settle.
//  It then captures sum/carry and returns them with a one-cycle grant/done pulse.
//  Sits between lab datapath clients and the single shared 16-bit adder instance.
// PARAMETERS
//  N_REQ       4   number of requesters (2..8)
//  WIDTH       16  operand/sum width; must match the adder
//  SETTLE_CYC  2   cycles the adder inputs are held before capture (>=1; 0 -> elaboration $error)
// PORTS
//  Clk       in   1              system clock, rising edge
//  Reset     in   1              asynchronous, active-high reset
//  req       in   N_REQ          level request per requester
//  a_in      in   N_REQ*WIDTH    operand A, requester i at [i*WIDTH +: WIDTH]
//  b_in      in   N_REQ*WIDTH    operand B, same packing
//  cin_in    in   N_REQ          carry-in per requester
//  add_x     out  WIDTH          to adder x (registered)
//  add_y     out  WIDTH          to adder y (registered)
//  add_z     out  1              to adder carry-in z (registered)
//  add_s     in   WIDTH          from adder sum s
//  add_c     in   1              from adder carry-out c
//  gnt       out  N_REQ          one-hot, valid only while done=1
//  done      out  1              result-valid pulse, 1 cycle
//  sum_out   out  WIDTH          captured sum; held until next capture
//  cout_out  out  1              captured carry-out; held until next capture
//  busy      out  1              high in SETTLE and DONE
// BEHAVIOUR
//  Reset: state=IDLE; gnt=0, done=0, busy=0, sum_out=0, cout_out=0, add_x/y/z=0; rr ptr=N_REQ-1.
//    Reset is async and aborts any transaction in flight; no done is issued for it.
//  FSM states: IDLE, SETTLE, DONE (all registered; all outputs registered).
//  IDLE, any req=1:
//    winner = first set req searching ptr+1, ptr+2, ... (mod N_REQ).
//    Latch a/b/cin[winner] into add_x/y/z and store winner index.
//    cnt<=0; go SETTLE.
//  IDLE, req=0: stay in IDLE; add_x/y/z hold their last values.
//  SETTLE: cnt++ each cycle; when cnt==SETTLE_CYC-1 capture add_s->sum_out, add_c->cout_out, go DONE.
//  DONE (1 cycle): done=1, gnt[winner]=1, ptr<=winner, then IDLE.
//  Latency: req sampled at edge E -> done high in the cycle after edge E+SETTLE_CYC+1.
//    This is SETTLE_CYC+2 cycles per transaction, with no back-to-back overlap.
//  Handshake:
//    Requester holds req until it sees its gnt; operands only need to be valid
//    in the IDLE cycle where it wins.
//    Dropping req before winning = withdrawn, with no side effect.
//    Grantee must drop req by the next IDLE cycle; otherwise it is re-served,
//    ranking last in round-robin order.
//  req/operand changes during SETTLE/DONE are ignored; the adder inputs stay stable.
//  Arithmetic: sum_out = (x+y+z) mod 2^WIDTH; cout_out = bit WIDTH of the result.
//    Unsigned semantics; no signed-overflow flag.
//  Fairness: with all N_REQ requesting continuously, grants rotate 0,1,..,N_REQ-1,0...
//    Any requester waits at most N_REQ-1 transactions.
//  Single requester: served every SETTLE_CYC+2 cycles.
// TESTING
//  1 Reset then req=0001, a0=0x00F0, b0=0x000F, cin=0 -> done at +SETTLE_CYC+2, gnt=0001, sum_out=0x00FF, cout_out=0
//  2 req0 a=0xFFFF b=0x0001 cin=0 -> sum_out=0x0000 cout_out=1; with cin=1 -> sum_out=0x0001 cout_out=1
//  3 req=1111 held 8 transactions, distinct operands -> gnt order 0001,0010,0100,1000,0001..., each sum correct for that index
//  4 req=0100 alone; change a2 during SETTLE -> result uses operands latched in IDLE; gnt=0100
//  5 Assert Reset mid-SETTLE -> all outputs 0 immediately, no done; next req=0001 wins first (ptr reset)
//  6 Hold req1 past gnt while req3 also set -> next gnt=1000 before 0010 is re-served

Source files
------------

// File: rtl/adder_share_arbiter.sv
// adder_share_arbiter: round-robin sequencer time-sharing one external adder among N_REQ requesters
module adder_share_arbiter #(
    parameter int N_REQ      = 4,
    parameter int WIDTH      = 16,
    parameter int SETTLE_CYC = 2
) (
    input  logic                   Clk,
    input  logic                   Reset,
    input  logic [N_REQ-1:0]       req,
    input  logic [N_REQ*WIDTH-1:0] a_in,
    input  logic [N_REQ*WIDTH-1:0] b_in,
    input  logic [N_REQ-1:0]       cin_in,
    output logic [WIDTH-1:0]       add_x,
    output logic [WIDTH-1:0]       add_y,
    output logic                   add_z,
    input  logic [WIDTH-1:0]       add_s,
    input  logic                   add_c,
    output logic [N_REQ-1:0]       gnt,
    output logic                   done,
    output logic [WIDTH-1:0]       sum_out,
    output logic                   cout_out,
    output logic                   busy
);
    localparam int IW = $clog2(N_REQ);
    localparam int CW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;

    if (SETTLE_CYC < 1) begin : g_bad_settle
        $error("SETTLE_CYC must be at least 1");
    end
    if (N_REQ < 2 || N_REQ > 8) begin : g_bad_nreq
        $error("N_REQ must be in 2..8");
    end

    typedef enum logic [1:0] {IDLE, SETTLE, DONE} state_t;

    state_t           state, nxt_state;
    logic [IW-1:0]    ptr, win, nxt_win, idx;
    logic [CW-1:0]    cnt;
    logic             last;
    logic [WIDTH-1:0] sel_a, sel_b;
    logic             sel_c;

    // round-robin pick: scan from farthest to nearest so the nearest set req after ptr wins
    always_comb begin
        nxt_win = '0;
        idx = '0;
        for (int k = N_REQ; k >= 1; k--) begin
            idx = IW'((int'(ptr) + k) % N_REQ);
            if (req[idx]) nxt_win = idx;
        end
    end

    // operand mux for the winning requester
    always_comb begin
        sel_a = '0;
        sel_b = '0;
        sel_c = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            if (IW'(i) == nxt_win) begin
                sel_a = a_in[i*WIDTH +: WIDTH];
                sel_b = b_in[i*WIDTH +: WIDTH];
                sel_c = cin_in[i];
            end
        end
    end

    // next-state logic
    always_comb begin
        last = cnt == CW'(SETTLE_CYC - 1);
        nxt_state = (state == IDLE)   ? (|req ? SETTLE : IDLE) :
                    (state == SETTLE) ? (last ? DONE : SETTLE) : IDLE;
    end

    // state register
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) state <= IDLE;
        else       state <= nxt_state;
    end

    // datapath: latch operands on win, capture result after settling, pulse grant/done
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            ptr      <= IW'(N_REQ - 1);
            win      <= '0;
            cnt      <= '0;
            add_x    <= '0;
            add_y    <= '0;
            add_z    <= 1'b0;
            sum_out  <= '0;
            cout_out <= 1'b0;
            gnt      <= '0;
            done     <= 1'b0;
            busy     <= 1'b0;
        end else begin
            done <= state == DONE;
            gnt  <= (state == DONE) ? {{(N_REQ-1){1'b0}}, 1'b1} << win : '0;
            busy <= nxt_state != IDLE;
            if (state == IDLE && |req) begin
                add_x <= sel_a;
                add_y <= sel_b;
                add_z <= sel_c;
                win   <= nxt_win;
                cnt   <= '0;
            end
            if (state == SETTLE) begin
                cnt <= cnt + 1'b1;
                if (last) begin
                    sum_out  <= add_s;
                    cout_out <= add_c;
                end
            end
            if (state == DONE) ptr <= win;
        end
    end
endmodule

// File: tb/tb_adder_share_arbiter.sv
// tb_adder_share_arbiter: scoreboard bench for the shared-adder round-robin sequencer
module tb_adder_share_arbiter;
    localparam int N = 4;
    localparam int W = 16;
    localparam int S = 2;

    typedef struct packed {
        logic [N-1:0] g;
        logic [W-1:0] s;
        logic         c;
    } ent_t;

    logic           Clk = 1'b0;
    logic           Reset = 1'b1;
    logic [N-1:0]   req = '0;
    logic [N-1:0]   cin = '0;
    logic [W-1:0]   a [N];
    logic [W-1:0]   b [N];
    logic [N*W-1:0] a_in, b_in;
    logic [W-1:0]   add_x, add_y, add_s, sum_out;
    logic           add_z, add_c, done, cout_out, busy;
    logic [N-1:0]   gnt;

    ent_t sb[$];
    ent_t mon_e;
    int   n_vec = 0;
    int   n_err = 0;

    for (genvar i = 0; i < N; i++) begin : g_pack
        assign a_in[i*W +: W] = a[i];
        assign b_in[i*W +: W] = b[i];
    end

    assign {add_c, add_s} = {1'b0, add_x} + {1'b0, add_y} + (W+1)'(add_z);

    always #5 Clk = ~Clk;

    adder_share_arbiter #(.N_REQ(N), .WIDTH(W), .SETTLE_CYC(S)) dut (
        .Clk(Clk), .Reset(Reset), .req(req), .a_in(a_in), .b_in(b_in), .cin_in(cin),
        .add_x(add_x), .add_y(add_y), .add_z(add_z), .add_s(add_s), .add_c(add_c),
        .gnt(gnt), .done(done), .sum_out(sum_out), .cout_out(cout_out), .busy(busy)
    );

    function automatic ent_t exp_for(int i);
        ent_t e;
        logic [W:0] r;
        r = {1'b0, a[i]} + {1'b0, b[i]} + (W+1)'(cin[i]);
        e.g = N'(1) << i;
        e.s = r[W-1:0];
        e.c = r[W];
        return e;
    endfunction

    // scoreboard: every done pulse pops one expected result
    always @(negedge Clk) begin
        if (done === 1'b1) begin
            if (sb.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_done gnt=%b sum=%h", gnt, sum_out);
            end else begin
                mon_e = sb.pop_front();
                n_vec++;
                if (gnt !== mon_e.g) begin
                    n_err++;
                    $display("FAIL gnt got=%b exp=%b", gnt, mon_e.g);
                end
                n_vec++;
                if (sum_out !== mon_e.s) begin
                    n_err++;
                    $display("FAIL sum_out got=%h exp=%h", sum_out, mon_e.s);
                end
                n_vec++;
                if (cout_out !== mon_e.c) begin
                    n_err++;
                    $display("FAIL cout_out got=%b exp=%b", cout_out, mon_e.c);
                end
            end
        end
    end

    task automatic wait_dones(input int n);
        int t;
        for (int k = 0; k < n; k++) begin
            t = 0;
            do begin
                @(negedge Clk);
                t++;
            end while (done !== 1'b1 && t < 100);
            if (done !== 1'b1) begin
                n_vec++;
                n_err++;
                $display("FAIL done_timeout got=%b exp=1", done);
            end
        end
    endtask

    task automatic serve(input logic [N-1:0] m, input int n);
        @(posedge Clk);
        #1 req = m;
        wait_dones(n);
        req = '0;
    endtask

    task automatic test_reset;
        for (int i = 0; i < N; i++) begin
            a[i] = '0;
            b[i] = '0;
        end
        Reset = 1'b1;
        repeat (3) @(posedge Clk);
        #1;
        n_vec++; if (gnt !== '0)     begin n_err++; $display("FAIL rst_gnt got=%b exp=0", gnt); end
        n_vec++; if (done !== 1'b0)  begin n_err++; $display("FAIL rst_done got=%b exp=0", done); end
        n_vec++; if (busy !== 1'b0)  begin n_err++; $display("FAIL rst_busy got=%b exp=0", busy); end
        n_vec++; if (sum_out !== '0) begin n_err++; $display("FAIL rst_sum got=%h exp=0", sum_out); end
        n_vec++; if (cout_out !== 1'b0) begin n_err++; $display("FAIL rst_cout got=%b exp=0", cout_out); end
        n_vec++; if ({add_x, add_y, add_z} !== '0) begin n_err++; $display("FAIL rst_add got=%h/%h/%b exp=0", add_x, add_y, add_z); end
        @(negedge Clk);
        Reset = 1'b0;
        repeat (2) @(posedge Clk);
        #1;
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL idle_busy got=%b exp=0", busy); end
    endtask

    task automatic test_basic;
        int lat;
        a[0] = 16'h00F0;
        b[0] = 16'h000F;
        cin = '0;
        sb.push_back({4'b0001, 16'h00FF, 1'b0});
        @(posedge Clk);
        #1 req = 4'b0001;
        @(posedge Clk);
        lat = 0;
        while (lat < 50) begin
            @(negedge Clk);
            lat++;
            if (done === 1'b1) break;
        end
        req = '0;
        n_vec++;
        if (lat != S + 2) begin
            n_err++;
            $display("FAIL latency got=%0d exp=%0d", lat, S + 2);
        end
    endtask

    task automatic test_carry;
        a[0] = 16'hFFFF;
        b[0] = 16'h0001;
        cin[0] = 1'b0;
        sb.push_back({4'b0001, 16'h0000, 1'b1});
        serve(4'b0001, 1);
        cin[0] = 1'b1;
        sb.push_back({4'b0001, 16'h0001, 1'b1});
        serve(4'b0001, 1);
    endtask

    task automatic test_round_robin;
        @(negedge Clk);
        Reset = 1'b1;
        @(negedge Clk);
        Reset = 1'b0;
        for (int i = 0; i < N; i++) begin
            a[i] = W'(16'h1357 * (i + 1));
            b[i] = W'(16'hF00F - 16'h0321 * i);
        end
        cin = 4'b1010;
        for (int k = 0; k < 8; k++) sb.push_back(exp_for(k % N));
        serve(4'b1111, 8);
    endtask

    task automatic test_operand_hold;
        a[2] = 16'h1234;
        b[2] = 16'h1111;
        cin[2] = 1'b1;
        sb.push_back(exp_for(2));
        @(posedge Clk);
        #1 req = 4'b0100;
        @(posedge Clk);
        #1;
        n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL settle_busy got=%b exp=1", busy); end
        a[2] = 16'hAAAA;
        b[2] = 16'h5555;
        cin[2] = 1'b0;
        req = '0;
        n_vec++; if (add_x !== 16'h1234) begin n_err++; $display("FAIL add_x_latched got=%h exp=1234", add_x); end
        wait_dones(1);
        n_vec++; if (add_y !== 16'h1111) begin n_err++; $display("FAIL add_y_held got=%h exp=1111", add_y); end
    endtask

    task automatic test_reset_mid;
        a[1] = 16'h0F0F;
        b[1] = 16'h0101;
        @(posedge Clk);
        #1 req = 4'b0010;
        @(posedge Clk);
        #1 Reset = 1'b1;
        #1;
        n_vec++; if ({busy, done, gnt} !== '0) begin n_err++; $display("FAIL midrst_ctl got=%b%b%b exp=0", busy, done, gnt); end
        n_vec++; if ({sum_out, cout_out} !== '0) begin n_err++; $display("FAIL midrst_res got=%h/%b exp=0", sum_out, cout_out); end
        n_vec++; if ({add_x, add_y, add_z} !== '0) begin n_err++; $display("FAIL midrst_add got=%h/%h/%b exp=0", add_x, add_y, add_z); end
        req = '0;
        @(negedge Clk);
        Reset = 1'b0;
        repeat (6) @(posedge Clk);
        a[0] = 16'h7777;
        b[0] = 16'h8889;
        cin = '0;
        sb.push_back({4'b0001, 16'h0000, 1'b1});
        serve(4'b1111, 1);
    endtask

    task automatic test_back_to_back;
        a[1] = 16'h2222; b[1] = 16'h3333; cin[1] = 1'b1;
        a[3] = 16'h8000; b[3] = 16'h8000; cin[3] = 1'b1;
        sb.push_back(exp_for(1));
        sb.push_back(exp_for(3));
        sb.push_back(exp_for(1));
        @(posedge Clk);
        #1 req = 4'b1010;
        wait_dones(2);
        req[3] = 1'b0;
        wait_dones(1);
        req = '0;
        repeat (8) @(posedge Clk);
        n_vec++;
        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL scoreboard_left got=%0d exp=0", sb.size());
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset;
        test_basic;
        test_carry;
        test_round_robin;
        test_operand_hold;
        test_reset_mid;
        test_back_to_back;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
